// File: rtl/y_demux_pkg.sv
// Shared constants, lane state encoding and select decode for the 1-to-4 demux.
package y_demux_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

  function automatic logic [NUM_LANES-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/y_demux_1to4_if.sv
// Upstream word channel plus four downstream lane channels and lane counters.
interface y_demux_1to4_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  import y_demux_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              in_data;
  logic [SEL_W-1:0]              in_sel;
  logic [NUM_LANES-1:0]          out_valid;
  logic [NUM_LANES-1:0]          out_ready;
  logic [NUM_LANES*WIDTH-1:0]    out_data;
  logic [NUM_LANES*CNT_W-1:0]    lane_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, lane_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, lane_cnt
  );

endinterface

// File: rtl/y_lane_buf.sv
// One-entry lane buffer: EMPTY/FULL state, held word and wrapping accept counter.
module y_lane_buf
  import y_demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_acc,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_out_ready,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt
);

  lane_state_t      r_state;
  lane_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  assign w_drain = (r_state == FULL) && i_out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (i_acc) w_state_nxt = FULL;
      FULL:  if (!i_acc && w_drain) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data is kept after a drain so the last word stays visible on the lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_acc) begin
      r_data <= i_data;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_full = (r_state == FULL);
  assign o_data = r_data;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/y_demux_1to4.sv
// 1-to-4 demultiplexer: routes each upstream word to the lane named by in_sel.
module y_demux_1to4
  import y_demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  y_demux_1to4_if.slave  bus
);

  logic [NUM_LANES-1:0] w_full;
  logic [NUM_LANES-1:0] w_sel_dec;
  logic [NUM_LANES-1:0] w_acc;

  always_comb begin
    w_sel_dec = '0;
    if (bus.in_valid) w_sel_dec = sel_onehot(bus.in_sel);
  end

  // Ready also when the target lane drains this same edge, giving full throughput.
  assign bus.in_ready  = !w_full[bus.in_sel] || bus.out_ready[bus.in_sel];
  assign w_acc         = w_sel_dec & {NUM_LANES{bus.in_ready}};
  assign bus.out_valid = w_full;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    y_lane_buf #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_acc       (w_acc[k]),
      .i_data      (bus.in_data),
      .i_out_ready (bus.out_ready[k]),
      .o_full      (w_full[k]),
      .o_data      (bus.out_data[k*WIDTH +: WIDTH]),
      .o_cnt       (bus.lane_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule
